mem_port_arb32: RTL and testbench

Two-to-one memory port arbiter sharing a single 32-bit memory request/response port between the instruction pre-fetch path (I) and the load/store path (D). It sits between the pre-fetch unit / LSU and the memory subsystem. It grants one request per cycle, with D given priority and a starvation guard for I. It holds a stalled grant stable until the memory accepts it, and tracks outstanding requests in an in-order tag FIFO so that each response is routed to the requester that issued it.

---
 rtl/mem_port_arb32.sv | 132 +++++++++++++
 tb/tb_mem_port_arb32.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb32.sv
// rtl/mem_port_arb32.sv - two-to-one I/D memory port arbiter with in-order response routing
// D has priority; I is forced through after C_STARVE_LIMIT consecutive D grants while it waits.
module mem_port_arb32 #(
  parameter int C_OSTD_DEPTH_X = 1,
  parameter int C_STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  input  logic        i_reqvalid_i,
  output logic        i_reqready_o,
  input  logic [1:0]  i_reqhpl_i,
  input  logic [31:0] i_reqaddr_i,
  output logic        i_rspvalid_o,
  input  logic        i_rspready_i,
  output logic        i_rsprerr_o,
  output logic [31:0] i_rspdata_o,
  input  logic        d_reqvalid_i,
  output logic        d_reqready_o,
  input  logic [1:0]  d_reqhpl_i,
  input  logic [31:0] d_reqaddr_i,
  input  logic        d_reqwr_i,
  input  logic [3:0]  d_reqbe_i,
  input  logic [31:0] d_reqwdata_i,
  output logic        d_rspvalid_o,
  input  logic        d_rspready_i,
  output logic        d_rsprerr_o,
  output logic [31:0] d_rspdata_o,
  output logic        m_reqvalid_o,
  input  logic        m_reqready_i,
  output logic [1:0]  m_reqhpl_o,
  output logic [31:0] m_reqaddr_o,
  output logic        m_reqwr_o,
  output logic [3:0]  m_reqbe_o,
  output logic [31:0] m_reqwdata_o,
  input  logic        m_rspvalid_i,
  output logic        m_rspready_o,
  input  logic        m_rsprerr_i,
  input  logic [31:0] m_rspdata_i
);

  localparam int DEPTH = 2 ** C_OSTD_DEPTH_X;
  localparam int CW    = C_OSTD_DEPTH_X + 1;
  localparam int PW    = C_OSTD_DEPTH_X;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [3:0]    STARVE_LIM = 4'(C_STARVE_LIMIT);
  localparam logic          TAG_I      = 1'b0;

  typedef enum logic [1:0] {ARB, HOLD_I, HOLD_D} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ostd_q;
  logic [3:0]      starve_q;
  logic [DEPTH-1:0] tag_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            full, empty, head;
  logic            arb_i, arb_d, sel_i, sel_d;
  logic            accept, rsp_hs;

  assign arb_i = i_reqvalid_i & (~d_reqvalid_i | (starve_q >= STARVE_LIM));
  assign arb_d = d_reqvalid_i & ~arb_i;

  // A held grant survives only while its requester keeps valid high.
  always_comb begin
    sel_i = arb_i;
    sel_d = arb_d;
    if (state_q == HOLD_I && i_reqvalid_i) begin
      sel_i = 1'b1;
      sel_d = 1'b0;
    end else if (state_q == HOLD_D && d_reqvalid_i) begin
      sel_i = 1'b0;
      sel_d = 1'b1;
    end
  end

  always_comb begin
    state_d = ARB;
    if (accept)     state_d = ARB;
    else if (sel_i) state_d = HOLD_I;
    else if (sel_d) state_d = HOLD_D;
  end

  assign full  = (ostd_q == FULL_CNT);
  assign empty = (ostd_q == '0);
  assign head  = tag_q[rd_ptr_q];

  assign m_reqvalid_o = (sel_i | sel_d) & ~full;
  assign i_reqready_o = m_reqready_i & ~full & sel_i;
  assign d_reqready_o = m_reqready_i & ~full & sel_d;
  assign accept       = m_reqvalid_o & m_reqready_i;

  assign m_reqhpl_o   = sel_i ? i_reqhpl_i  : d_reqhpl_i;
  assign m_reqaddr_o  = sel_i ? i_reqaddr_i : d_reqaddr_i;
  assign m_reqwr_o    = sel_i ? 1'b0        : d_reqwr_i;
  assign m_reqbe_o    = sel_i ? 4'hF        : d_reqbe_i;
  assign m_reqwdata_o = sel_i ? 32'h0       : d_reqwdata_i;

  assign i_rspvalid_o = m_rspvalid_i & ~empty & (head == TAG_I);
  assign d_rspvalid_o = m_rspvalid_i & ~empty & (head != TAG_I);
  assign m_rspready_o = ~empty & ((head == TAG_I) ? i_rspready_i : d_rspready_i);
  assign rsp_hs       = m_rspvalid_i & m_rspready_o;

  assign i_rsprerr_o  = m_rsprerr_i;
  assign d_rsprerr_o  = m_rsprerr_i;
  assign i_rspdata_o  = m_rspdata_i;
  assign d_rspdata_o  = m_rspdata_i;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q  <= ARB;
      ostd_q   <= '0;
      starve_q <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      if (accept) begin
        tag_q[wr_ptr_q] <= sel_d;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rsp_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !rsp_hs)      ostd_q <= ostd_q + 1'b1;
      else if (!accept && rsp_hs) ostd_q <= ostd_q - 1'b1;
      if (!i_reqvalid_i || (accept && sel_i))
        starve_q <= '0;
      else if (accept && sel_d && starve_q != 4'hF)
        starve_q <= starve_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arb32.sv
// tb/tb_mem_port_arb32.sv - directed bench for mem_port_arb32
// Depth 3 (8 outstanding), starvation limit 4.
module tb_mem_port_arb32;

  logic        clk = 1'b0;
  logic        resetb, clk_en;
  logic        i_reqvalid_i, i_reqready_o, i_rspvalid_o, i_rspready_i, i_rsprerr_o;
  logic [1:0]  i_reqhpl_i;
  logic [31:0] i_reqaddr_i, i_rspdata_o;
  logic        d_reqvalid_i, d_reqready_o, d_reqwr_i, d_rspvalid_o, d_rspready_i, d_rsprerr_o;
  logic [1:0]  d_reqhpl_i;
  logic [3:0]  d_reqbe_i;
  logic [31:0] d_reqaddr_i, d_reqwdata_i, d_rspdata_o;
  logic        m_reqvalid_o, m_reqready_i, m_reqwr_o, m_rspvalid_i, m_rspready_o, m_rsprerr_i;
  logic [1:0]  m_reqhpl_o;
  logic [3:0]  m_reqbe_o;
  logic [31:0] m_reqaddr_o, m_reqwdata_o, m_rspdata_i;

  int checks = 0;
  int errors = 0;
  int tb_ostd;

  always #5 clk = ~clk;

  mem_port_arb32 #(.C_OSTD_DEPTH_X(3), .C_STARVE_LIMIT(4)) u_dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
    .i_reqvalid_i(i_reqvalid_i), .i_reqready_o(i_reqready_o), .i_reqhpl_i(i_reqhpl_i),
    .i_reqaddr_i(i_reqaddr_i), .i_rspvalid_o(i_rspvalid_o), .i_rspready_i(i_rspready_i),
    .i_rsprerr_o(i_rsprerr_o), .i_rspdata_o(i_rspdata_o),
    .d_reqvalid_i(d_reqvalid_i), .d_reqready_o(d_reqready_o), .d_reqhpl_i(d_reqhpl_i),
    .d_reqaddr_i(d_reqaddr_i), .d_reqwr_i(d_reqwr_i), .d_reqbe_i(d_reqbe_i),
    .d_reqwdata_i(d_reqwdata_i), .d_rspvalid_o(d_rspvalid_o), .d_rspready_i(d_rspready_i),
    .d_rsprerr_o(d_rsprerr_o), .d_rspdata_o(d_rspdata_o),
    .m_reqvalid_o(m_reqvalid_o), .m_reqready_i(m_reqready_i), .m_reqhpl_o(m_reqhpl_o),
    .m_reqaddr_o(m_reqaddr_o), .m_reqwr_o(m_reqwr_o), .m_reqbe_o(m_reqbe_o),
    .m_reqwdata_o(m_reqwdata_o), .m_rspvalid_i(m_rspvalid_i), .m_rspready_o(m_rspready_o),
    .m_rsprerr_i(m_rsprerr_i), .m_rspdata_i(m_rspdata_i)
  );

  // Independent count of outstanding requests, used only to police the memory-side protocol.
  always @(posedge clk or negedge resetb) begin
    if (!resetb) tb_ostd <= 0;
    else if (clk_en)
      tb_ostd <= tb_ostd + ((m_reqvalid_o && m_reqready_i) ? 1 : 0)
                         - ((m_rspvalid_i && m_rspready_o) ? 1 : 0);
  end

  always @(negedge clk) begin
    if (resetb && m_rspvalid_i)
      assert (tb_ostd != 0) else $error("protocol: m_rspvalid_i with nothing outstanding");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clk_en = 1'b1;
    i_reqvalid_i = 0; i_reqhpl_i = 0; i_reqaddr_i = 0; i_rspready_i = 0;
    d_reqvalid_i = 0; d_reqhpl_i = 0; d_reqaddr_i = 0; d_reqwr_i = 0; d_reqbe_i = 0;
    d_reqwdata_i = 0; d_rspready_i = 0;
    m_reqready_i = 0; m_rspvalid_i = 0; m_rsprerr_i = 0; m_rspdata_i = 0;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    i_rspready_i = 1; d_rspready_i = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({i_reqready_o, d_reqready_o, i_rspvalid_o, d_rspvalid_o, m_reqvalid_o, m_rspready_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {i_reqready_o, d_reqready_o, i_rspvalid_o, d_rspvalid_o, m_reqvalid_o, m_rspready_o});
    end
    resetb = 1'b1;
    m_reqready_i = 1;
    #1;
    checks++;
    if ({i_reqready_o, d_reqready_o, m_reqvalid_o, m_rspready_o} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=0000", {i_reqready_o, d_reqready_o, m_reqvalid_o, m_rspready_o});
    end
  endtask

  task automatic test_single_i();
    step();
    i_reqvalid_i = 1; i_reqaddr_i = 32'h100; i_reqhpl_i = 2'b11;
    d_reqwr_i = 1; d_reqbe_i = 4'h3; d_reqwdata_i = 32'hCAFEF00D; d_reqhpl_i = 2'b00;
    m_reqready_i = 1;
    #1;
    checks++;
    if ({m_reqvalid_o, i_reqready_o, d_reqready_o} !== 3'b110) begin
      errors++;
      $display("FAIL single_i_grant got=%b exp=110", {m_reqvalid_o, i_reqready_o, d_reqready_o});
    end
    checks++;
    if ({m_reqhpl_o, m_reqaddr_o, m_reqwr_o, m_reqbe_o, m_reqwdata_o} !== {2'b11, 32'h100, 1'b0, 4'hF, 32'h0}) begin
      errors++;
      $display("FAIL single_i_fields got=%h/%h/%b/%h/%h exp=3/100/0/f/0",
               m_reqhpl_o, m_reqaddr_o, m_reqwr_o, m_reqbe_o, m_reqwdata_o);
    end
    step();
    i_reqvalid_i = 0;
    m_rspvalid_i = 1; m_rspdata_i = 32'hDEADBEEF; m_rsprerr_i = 0;
    #1;
    checks++;
    if ({i_rspvalid_o, d_rspvalid_o, m_rspready_o} !== 3'b101) begin
      errors++;
      $display("FAIL single_i_rsp got=%b exp=101", {i_rspvalid_o, d_rspvalid_o, m_rspready_o});
    end
    checks++;
    if (i_rspdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_i_data got=%h exp=deadbeef", i_rspdata_o);
    end
    step();
    m_rspvalid_i = 0;
    #1;
    checks++;
    if (m_rspready_o !== 1'b0) begin
      errors++;
      $display("FAIL single_i_empty got=%b exp=0", m_rspready_o);
    end
  endtask

  task automatic test_starve();
    logic [9:0] exp_grant_i;
    exp_grant_i = 10'b1000010000;
    step();
    i_reqvalid_i = 1; d_reqvalid_i = 1; d_reqwr_i = 0; m_reqready_i = 1;
    for (int k = 0; k < 10; k++) begin
      i_reqaddr_i = 32'h1000 + k;
      d_reqaddr_i = 32'h2000 + k;
      m_rspvalid_i = (k > 0);
      #1;
      checks++;
      if ({i_reqready_o, d_reqready_o} !== (exp_grant_i[k] ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starve_grant[%0d] got=%b exp=%b", k, {i_reqready_o, d_reqready_o},
                 exp_grant_i[k] ? 2'b10 : 2'b01);
      end
      checks++;
      if (m_reqaddr_o !== (exp_grant_i[k] ? 32'h1000 + k : 32'h2000 + k)) begin
        errors++;
        $display("FAIL starve_addr[%0d] got=%h", k, m_reqaddr_o);
      end
      if (k > 0) begin
        checks++;
        if ({i_rspvalid_o, d_rspvalid_o} !== (exp_grant_i[k-1] ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL starve_route[%0d] got=%b", k, {i_rspvalid_o, d_rspvalid_o});
        end
      end
      step();
    end
    i_reqvalid_i = 0; d_reqvalid_i = 0; m_rspvalid_i = 1;
    #1;
    checks++;
    if ({i_rspvalid_o, d_rspvalid_o} !== 2'b10) begin
      errors++;
      $display("FAIL starve_last_rsp got=%b exp=10", {i_rspvalid_o, d_rspvalid_o});
    end
    step();
    m_rspvalid_i = 0;
    #1;
    checks++;
    if (m_rspready_o !== 1'b0) begin
      errors++;
      $display("FAIL starve_drained got=%b exp=0", m_rspready_o);
    end
  endtask

  task automatic test_hold_d();
    step();
    i_reqvalid_i = 1; i_reqaddr_i = 32'h300;
    d_reqvalid_i = 1; d_reqaddr_i = 32'h200; d_reqwr_i = 1; d_reqbe_i = 4'h5; d_reqwdata_i = 32'h11223344;
    m_reqready_i = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({m_reqvalid_o, i_reqready_o, d_reqready_o} !== 3'b100) begin
        errors++;
        $display("FAIL hold_d_stall[%0d] got=%b exp=100", k, {m_reqvalid_o, i_reqready_o, d_reqready_o});
      end
      checks++;
      if ({m_reqaddr_o, m_reqwr_o, m_reqbe_o, m_reqwdata_o} !== {32'h200, 1'b1, 4'h5, 32'h11223344}) begin
        errors++;
        $display("FAIL hold_d_fields[%0d] got=%h/%b/%h/%h", k, m_reqaddr_o, m_reqwr_o, m_reqbe_o, m_reqwdata_o);
      end
      step();
    end
    m_reqready_i = 1;
    #1;
    checks++;
    if ({i_reqready_o, d_reqready_o} !== 2'b01) begin
      errors++;
      $display("FAIL hold_d_accept got=%b exp=01", {i_reqready_o, d_reqready_o});
    end
    step();
    i_reqvalid_i = 0; d_reqvalid_i = 0; m_reqready_i = 0; m_rspvalid_i = 1;
    #1;
    checks++;
    if ({i_rspvalid_o, d_rspvalid_o} !== 2'b01) begin
      errors++;
      $display("FAIL hold_d_rsp got=%b exp=01", {i_rspvalid_o, d_rspvalid_o});
    end
    step();
    m_rspvalid_i = 0;
  endtask

  task automatic test_hold_i_fallback();
    step();
    i_reqvalid_i = 1; i_reqaddr_i = 32'h400; d_reqvalid_i = 0; m_reqready_i = 0;
    #1;
    checks++;
    if ({m_reqvalid_o, m_reqaddr_o} !== {1'b1, 32'h400}) begin
      errors++;
      $display("FAIL hold_i_sel got=%b/%h exp=1/400", m_reqvalid_o, m_reqaddr_o);
    end
    step();
    d_reqvalid_i = 1; d_reqaddr_i = 32'h500; d_reqwr_i = 1;
    #1;
    checks++;
    if ({m_reqaddr_o, m_reqwr_o, m_reqbe_o} !== {32'h400, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL hold_i_kept got=%h/%b/%h exp=400/0/f", m_reqaddr_o, m_reqwr_o, m_reqbe_o);
    end
    step();
    i_reqvalid_i = 0;
    #1;
    checks++;
    if ({m_reqvalid_o, m_reqaddr_o, m_reqwr_o} !== {1'b1, 32'h500, 1'b1}) begin
      errors++;
      $display("FAIL hold_i_fallback got=%b/%h/%b exp=1/500/1", m_reqvalid_o, m_reqaddr_o, m_reqwr_o);
    end
    m_reqready_i = 1;
    #1;
    checks++;
    if ({i_reqready_o, d_reqready_o} !== 2'b01) begin
      errors++;
      $display("FAIL hold_i_fallback_ready got=%b exp=01", {i_reqready_o, d_reqready_o});
    end
    step();
    d_reqvalid_i = 0; m_reqready_i = 0; m_rspvalid_i = 1;
    #1;
    checks++;
    if ({i_rspvalid_o, d_rspvalid_o} !== 2'b01) begin
      errors++;
      $display("FAIL hold_i_fallback_rsp got=%b exp=01", {i_rspvalid_o, d_rspvalid_o});
    end
    step();
    m_rspvalid_i = 0;
  endtask

  task automatic test_full();
    step();
    i_reqvalid_i = 1; i_reqaddr_i = 32'h600; d_reqvalid_i = 0; m_reqready_i = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (i_reqready_o !== 1'b1) begin
        errors++;
        $display("FAIL full_fill[%0d] got=%b exp=1", k, i_reqready_o);
      end
      step();
    end
    #1;
    checks++;
    if ({m_reqvalid_o, i_reqready_o} !== 2'b00) begin
      errors++;
      $display("FAIL full_block got=%b exp=00", {m_reqvalid_o, i_reqready_o});
    end
    m_rspvalid_i = 1;
    #1;
    checks++;
    if ({m_rspready_o, i_rspvalid_o, m_reqvalid_o} !== 3'b110) begin
      errors++;
      $display("FAIL full_no_bypass got=%b exp=110", {m_rspready_o, i_rspvalid_o, m_reqvalid_o});
    end
    step();
    m_rspvalid_i = 0;
    #1;
    checks++;
    if ({m_reqvalid_o, i_reqready_o} !== 2'b11) begin
      errors++;
      $display("FAIL full_slot_freed got=%b exp=11", {m_reqvalid_o, i_reqready_o});
    end
    step();
    i_reqvalid_i = 0; m_reqready_i = 0; m_rspvalid_i = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (i_rspvalid_o !== 1'b1) begin
        errors++;
        $display("FAIL full_drain[%0d] got=%b exp=1", k, i_rspvalid_o);
      end
      step();
    end
    m_rspvalid_i = 0;
    #1;
    checks++;
    if (m_rspready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_drained got=%b exp=0", m_rspready_o);
    end
  endtask

  task automatic test_inorder_err();
    step();
    m_reqready_i = 1;
    i_reqvalid_i = 1; i_reqaddr_i = 32'h700;
    step();
    i_reqvalid_i = 0; d_reqvalid_i = 1; d_reqaddr_i = 32'h704; d_reqwr_i = 0;
    step();
    d_reqvalid_i = 0; i_reqvalid_i = 1; i_reqaddr_i = 32'h708;
    step();
    i_reqvalid_i = 0; m_reqready_i = 0;
    m_rspvalid_i = 1; m_rsprerr_i = 0; m_rspdata_i = 32'hA;
    #1;
    checks++;
    if ({i_rspvalid_o, d_rspvalid_o, i_rsprerr_o} !== 3'b100) begin
      errors++;
      $display("FAIL order_first_i got=%b exp=100", {i_rspvalid_o, d_rspvalid_o, i_rsprerr_o});
    end
    step();
    m_rsprerr_i = 1; m_rspdata_i = 32'hB; d_rspready_i = 0;
    #1;
    checks++;
    if ({d_rspvalid_o, i_rspvalid_o, m_rspready_o, d_rsprerr_o} !== 4'b1001) begin
      errors++;
      $display("FAIL order_d_stall got=%b exp=1001", {d_rspvalid_o, i_rspvalid_o, m_rspready_o, d_rsprerr_o});
    end
    step();
    #1;
    checks++;
    if ({d_rspvalid_o, i_rspvalid_o, d_rspdata_o, i_rspdata_o} !== {2'b10, 32'hB, 32'hB}) begin
      errors++;
      $display("FAIL order_d_held got=%b/%h/%h exp=10/b/b", {d_rspvalid_o, i_rspvalid_o}, d_rspdata_o, i_rspdata_o);
    end
    d_rspready_i = 1;
    #1;
    checks++;
    if (m_rspready_o !== 1'b1) begin
      errors++;
      $display("FAIL order_d_release got=%b exp=1", m_rspready_o);
    end
    step();
    m_rsprerr_i = 0;
    #1;
    checks++;
    if ({i_rspvalid_o, d_rspvalid_o, i_rsprerr_o} !== 3'b100) begin
      errors++;
      $display("FAIL order_third_i got=%b exp=100", {i_rspvalid_o, d_rspvalid_o, i_rsprerr_o});
    end
    step();
    m_rspvalid_i = 0;
    #1;
    checks++;
    if (m_rspready_o !== 1'b0) begin
      errors++;
      $display("FAIL order_drained got=%b exp=0", m_rspready_o);
    end
  endtask

  task automatic test_clk_en();
    step();
    i_reqvalid_i = 1; m_reqready_i = 1;
    step();
    i_reqvalid_i = 0; m_reqready_i = 0;
    clk_en = 0; m_rspvalid_i = 1;
    #1;
    checks++;
    if (i_rspvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL clk_en_rsp got=%b exp=1", i_rspvalid_o);
    end
    step();
    clk_en = 1;
    #1;
    checks++;
    if (i_rspvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL clk_en_hold got=%b exp=1", i_rspvalid_o);
    end
    step();
    m_rspvalid_i = 0;
    #1;
    checks++;
    if (m_rspready_o !== 1'b0) begin
      errors++;
      $display("FAIL clk_en_drained got=%b exp=0", m_rspready_o);
    end
  endtask

  task automatic test_reset_mid();
    step();
    i_reqvalid_i = 1; m_reqready_i = 1;
    step();
    step();
    i_reqvalid_i = 0; m_reqready_i = 0;
    #1;
    checks++;
    if (m_rspready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pending got=%b exp=1", m_rspready_o);
    end
    #1;
    resetb = 1'b0;
    #1;
    checks++;
    if (m_rspready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=0", m_rspready_o);
    end
    step();
    resetb = 1'b1;
    #1;
    checks++;
    if (m_rspready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_tags_dropped got=%b exp=0", m_rspready_o);
    end
    i_reqvalid_i = 1; m_reqready_i = 1;
    step();
    i_reqvalid_i = 0; m_reqready_i = 0; m_rspvalid_i = 1;
    #1;
    checks++;
    if ({i_rspvalid_o, m_rspready_o} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_recover got=%b exp=11", {i_rspvalid_o, m_rspready_o});
    end
    step();
    m_rspvalid_i = 0;
  endtask

  initial begin
    idle();
    resetb = 1'b0;
    test_reset();
    test_single_i();
    test_starve();
    test_hold_d();
    test_hold_i_fallback();
    test_full();
    test_inorder_err();
    test_clk_en();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
